// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: latches acquisition config, detects a trigger on the sample
// stream and writes a pre/post-trigger frame into a circular capture RAM.
module adc_capture_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int PRETRIG = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    cfg_channel,
  input  logic [11:0]   cfg_counter_max,
  input  logic [11:0]   cfg_level,
  input  logic          cfg_edge,
  input  logic          cfg_auto,
  input  logic [11:0]   sample_in,
  input  logic          sample_valid,
  output logic [1:0]    channel,
  output logic [11:0]   counter_max,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] start_addr,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRETRIG - 1);
  localparam logic [AW-1:0] TO_LAST   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_channel;
  logic [11:0]   r_counter_max;
  logic [11:0]   r_level;
  logic          r_edge;
  logic          r_auto;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_pre_cnt;
  logic [AW-1:0] r_to_cnt;
  logic [AW-1:0] r_post_cnt;
  logic [11:0]   r_prev;
  logic          r_prev_valid;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [11:0]   r_wr_data;
  logic [AW-1:0] r_trig_addr;

  logic w_busy;
  logic w_accept;
  logic w_arm;
  logic w_edge_hit;
  logic w_auto_hit;
  logic w_trigger;

  assign w_busy   = (r_state == S_PREFILL) || (r_state == S_ARMED) || (r_state == S_POST);
  // abort dominates both arm and sample acceptance in the same cycle
  assign w_accept = sample_valid && !abort && w_busy;
  assign w_arm    = arm && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_edge_hit = r_prev_valid &&
                      (r_edge ? ((r_prev > r_level) && (sample_in <= r_level))
                              : ((r_prev < r_level) && (sample_in >= r_level)));
  assign w_auto_hit = r_auto && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_trigger   = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (arm) w_state_nxt = S_PREFILL;
        S_PREFILL: if (sample_valid && (r_pre_cnt == PRE_LAST)) w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (sample_valid && (w_edge_hit || w_auto_hit)) begin
            w_trigger   = 1'b1;
            w_state_nxt = S_POST;
          end
        end
        S_POST: if (sample_valid && (r_post_cnt == AW'(1))) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_channel     <= '0;
      r_counter_max <= '0;
      r_level       <= '0;
      r_edge        <= 1'b0;
      r_auto        <= 1'b0;
      r_wr_ptr      <= '0;
      r_pre_cnt     <= '0;
      r_to_cnt      <= '0;
      r_post_cnt    <= '0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_trig_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_accept;
      if (w_arm) begin
        r_channel     <= cfg_channel;
        r_counter_max <= cfg_counter_max;
        r_level       <= cfg_level;
        r_edge        <= cfg_edge;
        r_auto        <= cfg_auto;
        r_wr_ptr      <= '0;
        r_pre_cnt     <= '0;
        r_to_cnt      <= '0;
        r_prev_valid  <= 1'b0;
      end
      if (w_accept) begin
        r_wr_addr    <= r_wr_ptr;
        r_wr_data    <= sample_in;
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_prev       <= sample_in;
        r_prev_valid <= 1'b1;
        if (r_state == S_PREFILL) r_pre_cnt <= r_pre_cnt + AW'(1);
        if (r_state == S_ARMED) r_to_cnt <= r_to_cnt + AW'(1);
        if (r_state == S_POST) r_post_cnt <= r_post_cnt - AW'(1);
        if (w_trigger) begin
          r_trig_addr <= r_wr_ptr;
          r_post_cnt  <= POST_INIT;
        end
      end
    end
  end

  assign channel     = r_channel;
  assign counter_max = r_counter_max;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign trig_addr   = r_trig_addr;
  assign start_addr  = r_trig_addr - PRE_OFS;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with DEPTH=16, PRETRIG=4; expected values
// are hand-computed from the frame geometry.
module tb_adc_capture_ctrl;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int PRETRIG = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PREFILL = 3'd1;
  localparam logic [2:0] ST_ARMED   = 3'd2;
  localparam logic [2:0] ST_POST    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          abort;
  logic [1:0]    cfg_channel;
  logic [11:0]   cfg_counter_max;
  logic [11:0]   cfg_level;
  logic          cfg_edge;
  logic          cfg_auto;
  logic [11:0]   sample_in;
  logic          sample_valid;
  logic [1:0]    channel;
  logic [11:0]   counter_max;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  adc_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .PRETRIG(PRETRIG)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
    .cfg_channel(cfg_channel), .cfg_counter_max(cfg_counter_max),
    .cfg_level(cfg_level), .cfg_edge(cfg_edge), .cfg_auto(cfg_auto),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .channel(channel), .counter_max(counter_max),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; land 1ns after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input logic [11:0] cm, input logic [11:0] lvl,
                         input logic edg, input logic aut);
    cfg_channel     = ch;
    cfg_counter_max = cm;
    cfg_level       = lvl;
    cfg_edge        = edg;
    cfg_auto        = aut;
  endtask

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    set_cfg(2'd0, 12'd0, 12'd0, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_channel", channel, 0);
    chk("rst_counter_max", counter_max, 0);
    chk("rst_state", dbg_state, ST_IDLE);

    // rising trigger with config latch
    set_cfg(2'd2, 12'd99, 12'd10, 1'b0, 1'b0);
    pulse_arm();
    chk("arm_channel", channel, 2);
    chk("arm_counter_max", counter_max, 99);
    chk("arm_state", dbg_state, ST_PREFILL);
    chk("arm_busy", busy, 1);
    chk("arm_no_write", wr_en, 0);
    set_cfg(2'd1, 12'd55, 12'd3, 1'b1, 1'b1);
    for (int v = 0; v < 4; v++) begin
      send(12'(v));
      chk("pre_wr_en", wr_en, 1);
      chk("pre_wr_addr", wr_addr, v);
      chk("pre_wr_data", wr_data, v);
    end
    chk("rise_armed", dbg_state, ST_ARMED);
    for (int v = 4; v < 10; v++) send(12'(v));
    chk("rise_still_armed", dbg_state, ST_ARMED);
    send(12'd10);
    chk("rise_post", dbg_state, ST_POST);
    chk("rise_trig_addr", trig_addr, 10);
    chk("rise_start_addr", start_addr, 6);
    chk("rise_trig_wr_addr", wr_addr, 10);

    // arm during POST is ignored
    pulse_arm();
    chk("post_arm_state", dbg_state, ST_POST);
    chk("post_arm_channel", channel, 2);
    chk("post_arm_cm", counter_max, 99);
    chk("post_arm_no_write", wr_en, 0);
    for (int v = 11; v < 21; v++) send(12'(v));
    chk("rise_not_done", done, 0);
    send(12'd21);
    chk("rise_last_wr_en", wr_en, 1);
    chk("rise_last_addr", wr_addr, 5);
    chk("rise_last_data", wr_data, 21);
    chk("rise_done", done, 1);
    chk("rise_done_busy", busy, 0);
    tick();
    chk("done_wr_idle", wr_en, 0);
    chk("done_hold", done, 1);
    chk("cfg_hold_channel", channel, 2);
    chk("cfg_hold_cm", counter_max, 99);
    send(12'd500);
    chk("done_sample_dropped", wr_en, 0);

    // falling trigger with wrap
    set_cfg(2'd1, 12'd55, 12'd5, 1'b1, 1'b0);
    pulse_arm();
    chk("fall_channel", channel, 1);
    chk("fall_cm", counter_max, 55);
    for (int v = 20; v > 5; v--) send(12'(v));
    chk("fall_armed", dbg_state, ST_ARMED);
    send(12'd5);
    chk("fall_post", dbg_state, ST_POST);
    chk("fall_trig_addr", trig_addr, 15);
    chk("fall_start_addr", start_addr, 11);
    send(12'd4);
    chk("fall_wrap_addr", wr_addr, 0);
    chk("fall_wrap_data", wr_data, 4);
    for (int v = 3; v >= 0; v--) send(12'(v));
    for (int i = 0; i < 5; i++) send(12'd0);
    chk("fall_not_done", done, 0);
    send(12'd0);
    chk("fall_last_addr", wr_addr, 10);
    chk("fall_done", done, 1);

    // auto trigger on constant input
    set_cfg(2'd3, 12'd7, 12'd10, 1'b0, 1'b1);
    pulse_arm();
    for (int i = 0; i < 19; i++) send(12'd5);
    chk("auto_armed", dbg_state, ST_ARMED);
    send(12'd5);
    chk("auto_post", dbg_state, ST_POST);
    chk("auto_trig_addr", trig_addr, 3);
    chk("auto_start_addr", start_addr, 15);
    for (int i = 0; i < 10; i++) send(12'd5);
    chk("auto_not_done", done, 0);
    send(12'd5);
    chk("auto_done", done, 1);
    chk("auto_last_addr", wr_addr, 14);

    // no auto: stays armed, address wraps
    set_cfg(2'd3, 12'd7, 12'd10, 1'b0, 1'b0);
    pulse_arm();
    for (int i = 0; i < 17; i++) send(12'd5);
    chk("noauto_wrap_addr", wr_addr, 0);
    for (int i = 17; i < 40; i++) send(12'd5);
    chk("noauto_armed", dbg_state, ST_ARMED);
    chk("noauto_addr", wr_addr, 7);

    // abort with a sample in ARMED
    abort = 1'b1;
    sample_in = 12'd11;
    sample_valid = 1'b1;
    tick();
    abort = 1'b0;
    sample_valid = 1'b0;
    chk("abort_state", dbg_state, ST_IDLE);
    chk("abort_no_write", wr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_channel_hold", channel, 3);

    // abort and arm together
    set_cfg(2'd1, 12'd200, 12'd10, 1'b0, 1'b0);
    abort = 1'b1;
    pulse_arm();
    abort = 1'b0;
    chk("abort_arm_state", dbg_state, ST_IDLE);
    chk("abort_arm_channel", channel, 3);
    chk("abort_arm_cm", counter_max, 7);

    // arm and sample in the same IDLE cycle
    arm = 1'b1;
    sample_in = 12'd77;
    sample_valid = 1'b1;
    tick();
    arm = 1'b0;
    sample_valid = 1'b0;
    chk("arm_sv_no_write", wr_en, 0);
    chk("arm_sv_state", dbg_state, ST_PREFILL);
    send(12'd88);
    chk("arm_sv_first_addr", wr_addr, 0);
    chk("arm_sv_first_data", wr_data, 88);

    // reset mid-POST
    send(12'd1);
    send(12'd2);
    send(12'd3);
    send(12'd20);
    chk("mid_post_state", dbg_state, ST_POST);
    chk("mid_post_trig", trig_addr, 4);
    send(12'd21);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_trig_addr", trig_addr, 0);
    chk("async_channel", channel, 0);
    chk("async_cm", counter_max, 0);
    chk("async_wr_addr", wr_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", dbg_state, ST_IDLE);
    chk("post_rst_wr_en", wr_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
